// File: rtl/ifu_fetch_stage_pkg.sv
// ============================================================================
// Module      : ifu_fetch_stage_pkg
// Description : Shared constants and FSM state type for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_stage_pkg;

    localparam int          c_INST_W   = 32;
    localparam int          c_XLEN     = 64;
    localparam logic [63:0] c_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_DROP = 2'b10
    } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_stage_if.sv
// ============================================================================
// Module      : ifu_fetch_stage_if
// Description : Imem request/response channel plus the fetch-to-decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifu_fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic            ifu_valid;
    logic            idu_ready;

    modport master (
        output imem_req_valid, imem_req_addr, id_inst, id_pc, ifu_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, idu_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_inst, id_pc, ifu_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data, idu_ready
    );
endinterface

`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
// ============================================================================
// Module      : ifu_fetch_queue
// Description : Small registered FIFO holding {pc, instruction} entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   enq,
    input  logic [WIDTH-1:0]       enq_data,
    input  logic                   deq,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (enq) begin
                r_mem[r_wr_ptr] <= enq_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_CW'(DEPTH));
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch_stage.sv
// ============================================================================
// Module      : ifu_fetch_stage
// Description : PC owner and imem fetch FSM feeding decode through a small queue.
//               Optional perf counters enabled by defining IFU_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_stage
    import ifu_fetch_stage_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = c_RESET_PC[XLEN-1:0],
    parameter int              FQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_pipeline,
    input  logic [XLEN-1:0]  redirect_pc,
    ifu_fetch_stage_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]      perf_fetch_cnt,
    output logic [63:0]      perf_stall_cnt
`endif
);
    localparam int c_CW      = $clog2(FQ_DEPTH) + 1;
    localparam int c_ENTRY_W = c_INST_W + XLEN;

    ifu_state_e            r_state;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_req_pc;

    logic [c_CW-1:0]       w_fq_count;
    logic                  w_fq_empty;
    logic                  w_fq_full;
    logic [c_ENTRY_W-1:0]  w_fq_head;
    logic                  w_req_valid;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_ifu_valid;
    logic [XLEN-1:0]       w_redirect_aligned;

    // Request only when a queue slot is reserved for the response; this is what
    // keeps the enqueue side from ever hitting a full queue.
    assign w_req_valid = rst_n && (r_state == S_REQ) && !flush_pipeline
                         && (w_fq_count < c_CW'(FQ_DEPTH));
    assign w_enq       = (r_state == S_WAIT) && bus.imem_resp_valid && !flush_pipeline;
    assign w_ifu_valid = !w_fq_empty && !flush_pipeline;
    assign w_deq       = w_ifu_valid && bus.idu_ready;
    assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (flush_pipeline) begin
            r_pc <= w_redirect_aligned;
            case (r_state)
                S_WAIT:  r_state <= bus.imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  r_state <= bus.imem_resp_valid ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_valid && bus.imem_req_ready) begin
                        r_req_pc <= r_pc;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        r_pc    <= r_req_pc + XLEN'(4);
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_resp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    ifu_fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fetch_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush_pipeline),
        .enq      (w_enq),
        .enq_data ({r_req_pc, bus.imem_resp_data}),
        .deq      (w_deq),
        .head     (w_fq_head),
        .empty    (w_fq_empty),
        .full     (w_fq_full),
        .count    (w_fq_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.ifu_valid      = w_ifu_valid;
    assign bus.id_inst        = w_fq_head[c_INST_W-1:0];
    assign bus.id_pc          = w_fq_head[c_ENTRY_W-1:c_INST_W];

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_enq && w_fq_full && !w_deq));

`ifdef IFU_PERF_EN
    logic [63:0] r_perf_fetch_cnt;
    logic [63:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 64'd1;
            end
            if (w_ifu_valid && !bus.idu_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_stage.sv
// ============================================================================
// Module      : tb_ifu_fetch_stage
// Description : Directed bench for ifu_fetch_stage with imem model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch_stage;

    localparam logic [63:0] c_RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_pipeline = 1'b0;
    logic [63:0] redirect_pc = '0;

    ifu_fetch_stage_if #(.XLEN(64)) bus ();

`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu_fetch_stage #(
        .XLEN     (64),
        .RESET_PC (c_RST_PC),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_pipeline (flush_pipeline),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [95:0] sb [$];
    int          mem_delay = 1;
    bit          mem_bad   = 1'b0;
    bit          mem_out   = 1'b0;
    bit          mem_stale = 1'b0;
    logic [63:0] mem_addr  = '0;
    int          mem_cnt   = 0;
    logic [63:0] n_enq     = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F ^ {a[63:48], 16'h0013};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic wait_hs(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_handshake");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model plus output monitor; scoreboard entries are pushed when a
    // response is delivered that the fetch stage must keep.
    initial begin : mem_model
        logic        hs, rsp, fl;
        logic [95:0] exp_e;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                mem_out   = 1'b0;
                mem_stale = 1'b0;
                n_enq     = '0;
            end else begin
                hs  = bus.imem_req_valid && bus.imem_req_ready;
                rsp = bus.imem_resp_valid;
                fl  = flush_pipeline;
                if (fl) chk("ifu_valid_in_flush", {63'd0, bus.ifu_valid}, 64'd0);
                if (bus.ifu_valid) begin
                    chk("no_dead_beef", {63'd0, bus.id_inst == 32'hDEAD_BEEF}, 64'd0);
                    if (bus.idu_ready) begin
                        n_tests++;
                        assert (sb.size() != 0) else begin
                            n_fail++;
                            $error("FAIL unexpected_output: observed pc %h expected none", bus.id_pc);
                        end
                        if (sb.size() != 0) begin
                            exp_e = sb.pop_front();
                            chk("id_pc", bus.id_pc, exp_e[95:32]);
                            chk("id_inst", {32'd0, bus.id_inst}, {32'd0, exp_e[31:0]});
                        end
                    end
                end
                if (rsp) begin
                    if (!mem_stale && !fl) begin
                        sb.push_back({mem_addr, bus.imem_resp_data});
                        n_enq++;
                    end
                    mem_out   = 1'b0;
                    mem_stale = 1'b0;
                end
                if (fl) begin
                    sb.delete();
                    if (mem_out) mem_stale = 1'b1;
                end
                if (hs) begin
                    n_tests++;
                    assert (!mem_out) else begin
                        n_fail++;
                        $error("FAIL one_outstanding: observed second request expected none");
                    end
                    mem_out  = 1'b1;
                    mem_addr = bus.imem_req_addr;
                    mem_cnt  = mem_delay;
                end
            end
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (rst_n && mem_out && mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_bad ? 32'hDEAD_BEEF : mem_word(mem_addr);
                    mem_bad = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] held_addr;
        bus.imem_req_ready = 1'b1;
        bus.idu_ready      = 1'b0;
        rst_n              = 1'b0;

        // Reset state, memory ready
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("rst_ifu_valid", {63'd0, bus.ifu_valid}, 64'd0);
        chk("rst_id_inst", {32'd0, bus.id_inst}, 64'd0);
        chk("rst_id_pc", bus.id_pc, 64'd0);
`ifdef IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 64'd0);
        chk("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif

        // First fetches and latency
        step();
        rst_n         = 1'b1;
        bus.idu_ready = 1'b1;
        @(negedge clk);
        chk("req0_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("req0_addr", bus.imem_req_addr, c_RST_PC);
        @(negedge clk);
        chk("wait_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("wait_ifu_valid", {63'd0, bus.ifu_valid}, 64'd0);
        @(negedge clk);
        chk("lat_ifu_valid", {63'd0, bus.ifu_valid}, 64'd1);
        chk("lat_id_pc", bus.id_pc, c_RST_PC);
        chk("req1_addr", bus.imem_req_addr, c_RST_PC + 64'd4);
        chk("req1_valid", {63'd0, bus.imem_req_valid}, 64'd1);

        // Decode stall: queue fills, requests stop
        step();
        bus.idu_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("stall_ifu_valid", {63'd0, bus.ifu_valid}, 64'd1);
        chk("stall_head_pc", bus.id_pc, c_RST_PC + 64'd4);
        chk("stall_fq_level", 64'(sb.size()), 64'd2);
        step();
        bus.idu_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 20; i++) begin
            bus.idu_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.idu_ready = 1'b1;

        // Flush while waiting; late poisoned response is dropped
        mem_delay = 3;
        mem_bad   = 1'b1;
        wait_hs(20);
        step();
        flush_pipeline = 1'b1;
        redirect_pc    = 64'h8000_0100;
        @(negedge clk);
        chk("flush_wait_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        step();
        flush_pipeline = 1'b0;
        mem_delay      = 1;
        wait_hs(20);
        chk("redirect_addr", bus.imem_req_addr, 64'h8000_0100);
        repeat (6) step();

        // Flush coincident with the response, unaligned target
        wait_hs(20);
        step();
        flush_pipeline = 1'b1;
        redirect_pc    = 64'h8000_0203;
        step();
        flush_pipeline = 1'b0;
        @(negedge clk);
        chk("same_cycle_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("same_cycle_req_addr", bus.imem_req_addr, 64'h8000_0200);
        repeat (6) step();

        // Memory not ready: request must hold
        bus.imem_req_ready = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus.imem_req_valid;
            end
            if (!seen) fail_now("wait_req_valid");
        end
        held_addr = bus.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, bus.imem_req_valid}, 64'd1);
            chk("hold_addr", bus.imem_req_addr, held_addr);
        end
        step();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_addr", bus.imem_req_addr, held_addr);
        repeat (8) step();
`ifdef IFU_PERF_EN
        begin
            bit quiet;
            quiet = 1'b0;
            for (int i = 0; i < 4 && !quiet; i++) begin
                @(negedge clk);
                quiet = !bus.imem_resp_valid;
            end
            chk("perf_fetch_cnt", perf_fetch_cnt, n_enq);
        end
`endif

        // PC wraps modulo 2^64
        step();
        flush_pipeline = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        flush_pipeline = 1'b0;
        wait_hs(20);
        chk("wrap_addr_top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_hs(20);
        chk("wrap_addr_zero", bus.imem_req_addr, 64'd0);
        repeat (4) step();

        // Reset in the middle of a fetch
        wait_hs(20);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("midrst_ifu_valid", {63'd0, bus.ifu_valid}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_addr", bus.imem_req_addr, c_RST_PC);
        chk("midrst_req_valid2", {63'd0, bus.imem_req_valid}, 64'd1);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
